sram_op_arbiter: RTL

SRAM_OP_ARBITER -- requirements
Module: sram_op_arbiter

---
 rtl/sram_op_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/sram_op_arbiter.sv
// sram_op_arbiter: round-robin write/read page grant arbiter for a shared SRAM.
// Each side has its own rotating pointer. Write grants hold back RESERVE free
// pages. Read grants go only to ports that still own a page. A pause FSM drains
// the arbiter before reporting it is paused.
// Optional feature: define PORT_QUOTA_EN to cap each port's pages at 'quota'.
module sram_op_arbiter #(
    parameter int PORT_NUM   = 16,
    parameter int ADDR_WIDTH = 11,
    parameter int RESERVE    = 2,
    localparam int PW        = $clog2(PORT_NUM)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 pause,
    input  logic [PORT_NUM-1:0]                  wr_req,
    input  logic [PORT_NUM-1:0]                  rd_req,
    input  logic [PORT_NUM-1:0][ADDR_WIDTH-1:0]  rd_req_addr,
    input  logic [ADDR_WIDTH-1:0]                free_space,
    input  logic [PORT_NUM-1:0][ADDR_WIDTH-1:0]  port_amount,
    input  logic [ADDR_WIDTH-1:0]                quota,
    output logic [PORT_NUM-1:0]                  wr_gnt,
    output logic [PORT_NUM-1:0]                  rd_gnt,
    output logic                                 wr_op,
    output logic [PW-1:0]                        wr_port,
    output logic                                 rd_op,
    output logic [PW-1:0]                        rd_port,
    output logic [ADDR_WIDTH-1:0]                rd_addr,
    output logic                                 paused
);

    // Two extra bits so the corrected counts can go negative without wrapping.
    localparam int EW = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {RUN, DRAIN, PAUSED} state_t;

    state_t               state;
    state_t               state_next;
    logic                 grant_en;

    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;

    logic [EW-1:0]        eff_free;
    logic                 write_ok;
    logic [EW-1:0]        eff_amount [PORT_NUM];
    logic [PORT_NUM-1:0]  wr_elig;
    logic [PORT_NUM-1:0]  rd_elig;

    logic                 wr_found;
    logic [PW-1:0]        wr_win;
    logic                 rd_found;
    logic [PW-1:0]        rd_win;

    // Adds an offset below PORT_NUM to a port index, wrapping modulo PORT_NUM.
    function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= PORT_NUM) begin
            s = s - PORT_NUM;
        end
        return PW'(s);
    endfunction

    // State register for the pause/drain handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state. Grants are enabled only in RUN when no pause is requested.
    always_comb begin
        state_next = state;
        grant_en   = 1'b0;
        case (state)
            RUN: begin
                if (pause) begin
                    state_next = DRAIN;
                end else begin
                    grant_en = 1'b1;
                end
            end
            DRAIN: begin
                state_next = pause ? PAUSED : RUN;
            end
            PAUSED: begin
                if (!pause) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign paused = (state == PAUSED);

    // free_space and port_amount lag one cycle, so correct them with the
    // operations currently on the outputs.
    always_comb begin
        eff_free = EW'(free_space) - EW'(wr_op) + EW'(rd_op);
        write_ok = !eff_free[EW-1] && (eff_free > EW'(RESERVE));
        for (int p = 0; p < PORT_NUM; p++) begin
            eff_amount[p] = EW'(port_amount[p])
                          - EW'(rd_op && (rd_port == PW'(p)))
                          + EW'(wr_op && (wr_port == PW'(p)));
            rd_elig[p] = rd_req[p] && !eff_amount[p][EW-1] && (eff_amount[p] != '0);
`ifdef PORT_QUOTA_EN
            wr_elig[p] = wr_req[p] && write_ok && (eff_amount[p] < EW'(quota));
`else
            wr_elig[p] = wr_req[p] && write_ok;
`endif
        end
    end

`ifndef PORT_QUOTA_EN
    // The quota input only matters when the quota feature is compiled in.
    logic quota_unused;
    assign quota_unused = ^quota;
`endif

    // Round-robin search on each side: the first eligible port from the pointer wins.
    always_comb begin
        wr_found = 1'b0;
        wr_win   = '0;
        rd_found = 1'b0;
        rd_win   = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            if (!wr_found && wr_elig[wrap_idx(wr_ptr, i)]) begin
                wr_found = 1'b1;
                wr_win   = wrap_idx(wr_ptr, i);
            end
            if (!rd_found && rd_elig[wrap_idx(rd_ptr, i)]) begin
                rd_found = 1'b1;
                rd_win   = wrap_idx(rd_ptr, i);
            end
        end
    end

    // Registered grants and strobes. Port, address and pointer hold when idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_gnt  <= '0;
            rd_gnt  <= '0;
            wr_op   <= 1'b0;
            rd_op   <= 1'b0;
            wr_port <= '0;
            rd_port <= '0;
            rd_addr <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            wr_op  <= grant_en && wr_found;
            rd_op  <= grant_en && rd_found;
            wr_gnt <= (grant_en && wr_found) ? (PORT_NUM'(1) << wr_win) : '0;
            rd_gnt <= (grant_en && rd_found) ? (PORT_NUM'(1) << rd_win) : '0;
            if (grant_en && wr_found) begin
                wr_port <= wr_win;
                wr_ptr  <= wrap_idx(wr_win, 1);
            end
            if (grant_en && rd_found) begin
                rd_port <= rd_win;
                rd_addr <= rd_req_addr[rd_win];
                rd_ptr  <= wrap_idx(rd_win, 1);
            end
        end
    end

endmodule
